// File: rtl/lfsr_pkg.sv
// Shared types, default LFSR geometry and the Fibonacci next-state function
// used by lfsr_core and the lfsr_rng_arbiter top.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        DELIVER = 2'd2
    } state_e;

    localparam int              LFSR_N     = 3;
    localparam logic [LFSR_N-1:0] LFSR_TAPS = 3'b110;
    localparam int              LFSR_MAX_N = 64;

    // Width-generic shift-left step: bit 0 takes the XOR of the tapped bits.
    // Callers pass zero-extended operands and keep only the low n bits.
    function automatic logic [LFSR_MAX_N-1:0] lfsr_next(
        input logic [LFSR_MAX_N-1:0] cur,
        input logic [LFSR_MAX_N-1:0] taps,
        input int                    n
    );
        logic [LFSR_MAX_N-1:0] nxt;
        nxt = '0;
        for (int i = 1; i < LFSR_MAX_N; i++) begin
            if (i < n) begin
                nxt[i] = cur[i-1];
            end
        end
        nxt[0] = ^(cur & taps);
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// N-bit Fibonacci LFSR register with seed load, step enable and zero-seed
// substitution; resets to 1 so the all-zero lock-up state is never entered.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int            N    = LFSR_N,
    parameter logic [N-1:0]  TAPS = LFSR_TAPS
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load_en,
    input  logic [N-1:0] load_seed,
    input  logic         step_en,
    output logic [N-1:0] state,
    output logic [N-1:0] state_next
);

    logic [N-1:0]            state_q;
    logic [N-1:0]            state_d;
    logic [LFSR_MAX_N-1:0]   wide_next;

    assign wide_next  = lfsr_next(LFSR_MAX_N'(state_q), LFSR_MAX_N'(TAPS), N);
    assign state_next = wide_next[N-1:0];
    assign state      = state_q;

    generate
        if (N < LFSR_MAX_N) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^wide_next[LFSR_MAX_N-1:N];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        if (load_en) begin
            state_d = (load_seed == '0) ? N'(1) : load_seed;
        end else if (step_en) begin
            state_d = state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= N'(1);
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Two-port round-robin arbiter and sequencer around one shared LFSR.
// Optional period checker (wrap / period_err) enabled by LFSR_PERIOD_CHK_EN.
module lfsr_rng_arbiter
    import lfsr_pkg::*;
#(
    parameter int            N     = LFSR_N,
    parameter logic [N-1:0]  TAPS  = LFSR_TAPS,
    parameter int            STEPS = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         load_valid,
    input  logic [N-1:0] load_seed,
    output logic         load_ready,
    input  logic [1:0]   req,
    output logic [1:0]   gnt,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_data,
`ifdef LFSR_PERIOD_CHK_EN
    output logic         wrap,
    output logic         period_err,
`endif
    output logic         busy
);

    localparam logic [3:0] STEP_LAST = 4'(STEPS - 1);

    state_e       state_q, state_d;
    logic         rr_ptr_q, rr_ptr_d;
    logic [3:0]   step_cnt_q, step_cnt_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;

    logic         load_en;
    logic         step_en;
    logic         win;
    logic [1:0]   gnt_c;
    logic [N-1:0] lfsr_state;
    logic [N-1:0] lfsr_next_val;
    logic         unused_state;

    lfsr_core #(
        .N    (N),
        .TAPS (TAPS)
    ) u_core (
        .clk        (sys_clk),
        .srst       (sys_rst),
        .load_en    (load_en),
        .load_seed  (load_seed),
        .step_en    (step_en),
        .state      (lfsr_state),
        .state_next (lfsr_next_val)
    );

    assign unused_state = ^lfsr_state;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        step_cnt_d  = step_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        load_en     = 1'b0;
        step_en     = 1'b0;
        gnt_c       = 2'b00;
        win         = req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;

        case (state_q)
            IDLE: begin
                // Seed loading wins over requests; no grant in a load cycle.
                if (load_valid) begin
                    load_en = 1'b1;
                end else if (|req) begin
                    gnt_c      = win ? 2'b10 : 2'b01;
                    rsp_id_d   = win;
                    rr_ptr_d   = ~win;
                    step_cnt_d = 4'd0;
                    state_d    = ADVANCE;
                end
            end
            ADVANCE: begin
                step_en    = 1'b1;
                step_cnt_d = step_cnt_q + 4'd1;
                if (step_cnt_q == STEP_LAST) begin
                    rsp_data_d  = lfsr_next_val;
                    rsp_valid_d = 1'b1;
                    state_d     = DELIVER;
                end
            end
            DELIVER: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            step_cnt_q  <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            step_cnt_q  <= step_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // The grant is a combinational pulse in the IDLE cycle that wins arbitration.
    assign gnt        = sys_rst ? 2'b00 : gnt_c;
    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

`ifdef LFSR_PERIOD_CHK_EN
    localparam logic [N-1:0] PERIOD_MAX = {N{1'b1}};

    logic [N-1:0] seed_ref_q, seed_ref_d;
    logic [N-1:0] period_cnt_q, period_cnt_d;
    logic         wrap_q, wrap_d;
    logic         period_err_q, period_err_d;

    always_comb begin
        seed_ref_d   = seed_ref_q;
        period_cnt_d = period_cnt_q;
        period_err_d = period_err_q;
        wrap_d       = 1'b0;
        if (load_en) begin
            seed_ref_d   = (load_seed == '0) ? N'(1) : load_seed;
            period_cnt_d = '0;
            period_err_d = 1'b0;
        end else if (step_en) begin
            if (lfsr_next_val == seed_ref_q) begin
                wrap_d       = 1'b1;
                period_cnt_d = '0;
            end else begin
                period_cnt_d = period_cnt_q + N'(1);
                // A maximal-length sequence must wrap before the counter saturates.
                if (period_cnt_q == PERIOD_MAX - N'(1)) begin
                    period_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            seed_ref_q   <= N'(1);
            period_cnt_q <= '0;
            wrap_q       <= 1'b0;
            period_err_q <= 1'b0;
        end else begin
            seed_ref_q   <= seed_ref_d;
            period_cnt_q <= period_cnt_d;
            wrap_q       <= wrap_d;
            period_err_q <= period_err_d;
        end
    end

    assign wrap       = wrap_q;
    assign period_err = period_err_q;
`endif

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
- Controller and 2-port arbiter around one shared N-bit Fibonacci LFSR (pseudo-random number source).
- Requesters raise req; the block grants one, advances the LFSR STEPS times to decorrelate, then returns the value on a valid/ready response channel tagged with requester id.
- Also sequences seed loading, and blocks the all-zero seed.
- Sits between the LFSR datapath and consumers such as the test-pattern and dice logic.

Parameters:
- N, 3, LFSR width (N >= 3).
- TAPS, 3'b110, feedback mask (N bits); fb = XOR-reduce(state & TAPS).
- STEPS, 2, LFSR advances per request (1..15).

Ports:
- sys_clk  in  1  clock, rising edge.
- sys_rst  in  1  synchronous active-high reset.
- load_valid  in  1  seed load request.
- load_seed  in  N  seed value.
- load_ready  out  1  seed load accepted when high together with load_valid.
- req  in  2  per-requester random-number request, level.
- gnt  out  2  one-hot grant pulse, 1 cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready.
- rsp_id  out  1  index of the granted requester.
- rsp_data  out  N  random value.
- busy  out  1  high outside IDLE.

Behaviour:
- Reset (sync, active-high): state=IDLE, lfsr=1, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0 (requester 0 has priority next), step_cnt=0, busy=0. Reset mid-operation aborts any response; no partial handshake survives.
- LFSR step: lfsr <= {lfsr[N-2:0], fb}. For N=3, TAPS=110, seed 001 the sequence is 001,010,101,011,111,110,100,001 (period 7).
- FSM IDLE:
  - load_ready=1 only in IDLE.
  - load_valid has priority over req: lfsr <= (load_seed==0) ? 1 : load_seed; stay in IDLE; no gnt that cycle.
  - Otherwise, if any req: grant per round-robin (rr_ptr first, else the other). gnt pulses for that cycle, rsp_id latched, rr_ptr <= the other requester, step_cnt=0, go to ADVANCE.
- FSM ADVANCE: step the LFSR each cycle; step_cnt++. After STEPS steps: rsp_data <= the post-step value, rsp_valid=1, go to DELIVER.
- FSM DELIVER: hold rsp_valid/rsp_id/rsp_data stable until rsp_ready. On the handshake cycle clear rsp_valid and go to IDLE. The LFSR does not move in DELIVER or IDLE.
- Latency: gnt at cycle T, rsp_valid first high at T+STEPS+1. With rsp_ready held high, the next gnt comes at the earliest at T+STEPS+2.
- Simultaneous req==2'b11: alternate strictly. A requester that is held high is served at most once per two grants while the other is also pending.
- req dropped after gnt: the response is still delivered. req is not sampled outside IDLE.
- load_valid outside IDLE: ignored, load_ready=0; the source must hold it.
- Zero state is unreachable: reset to 1 and zero seed replaced by 1.
- busy = (state != IDLE).

Optional Feature:
- Macro LFSR_PERIOD_CHK_EN.
- Defined:
  - Extra output wrap (1 bit), plus an internal N-bit step counter cleared on reset and on seed load.
  - wrap pulses 1 cycle when an ADVANCE step returns the LFSR to the last loaded seed (or 1 after reset).
  - The counter increments per step. If it reaches 2^N-1 without a wrap, sticky output period_err=1, cleared only by reset or load.
- Undefined: no wrap/period_err ports, no counter; all other behaviour identical.

Decomposition:
- Package lfsr_pkg:
  - state enum {IDLE, ADVANCE, DELIVER};
  - default width/taps constants (LFSR_N=3, LFSR_TAPS=3'b110);
  - the next-state function.
- Sub-module lfsr_core: N-bit register with load, step enable and zero-seed substitution, instantiated once.
- Arbiter and FSM live in the top.

Test Plan:
- Reset then req=01, rsp_ready=1: gnt=01 at T; rsp_valid at T+3 with rsp_id=0, rsp_data=101 (001 -> 010 -> 101).
- load_seed=000 with load_valid in IDLE: load_ready=1. Then a req=10 response gives rsp_data=101 (substituted seed 1). Load with req also high: no gnt that cycle.
- req=11 held, rsp_ready=1: grants alternate 01,10,01,10. rsp_data follows the sequence 101,111,100,010 (two steps each).
- rsp_ready=0 for 5 cycles in DELIVER: rsp_valid/rsp_data/rsp_id stable, busy=1, load_ready=0, no new gnt. Raising rsp_ready completes, and IDLE follows next cycle.
- sys_rst asserted during ADVANCE: next cycle rsp_valid=0, busy=0, lfsr=1. A subsequent request returns 101.
- With LFSR_PERIOD_CHK_EN, STEPS=1, seed 001, 7 requests: wrap pulses exactly on the 7th step and period_err stays 0.
